// File: rtl/serial_out_shifter_pkg.sv
// rtl/serial_out_shifter_pkg.sv - shared types and sizing helper for the serial-out shifter
// Contents:
//   state_t - shifter state encoding (ST_IDLE, ST_SHIFT, ST_PARITY)
//   clog2   - counter width for values 0..n-1, never less than 1 bit
package serial_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Width needed to hold 0..n-1. Returns at least 1 so that n=1 still
    // yields a legal one-bit counter that simply stays at zero.
    function automatic int clog2(input int unsigned n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (((n - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_out_shifter_if.sv
// rtl/serial_out_shifter_if.sv - parallel load handshake between a word source and the shifter
// Signals:
//   load_valid - source presents a word
//   load_ready - shifter can accept a word this cycle
//   load_data  - DATA_W-bit word to serialise
//   msb_first  - bit order for this word (1 = MSB first)
// Modports: master (word source), slave (shifter)
interface serial_out_shifter_if #(
    parameter int DATA_W = 8
);
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              msb_first;

    modport master (
        output load_valid,
        output load_data,
        output msb_first,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  msb_first,
        output load_ready
    );
endinterface

// File: rtl/serial_out_shifter_bit_timer.sv
// rtl/serial_out_shifter_bit_timer.sv - bit-period divider producing a tick in the last cycle of each bit
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   en   - count while high; held at zero while low
//   tick - high in the final cycle of each DIV-cycle bit period
module bit_timer
    import serial_out_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW  = clog2(DIV);
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    // With DIV=1 TOP is zero, so tick follows en and the count never moves.
    assign tick = en && (div_cnt == TOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (!en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_out_shifter.sv
// rtl/serial_out_shifter.sv - parallel-load, serial-out word shifter with selectable bit order
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   ld        - load handshake (serial_out_shifter_if.slave)
//   serialOut - serial data stream, IDLE_LEVEL when no word is in flight
//   busy      - high while a word (and its parity bit) is being shifted
//   done      - one-cycle pulse in the final cycle of each word
// Optional feature: define SERIAL_OUT_PARITY_EN to append a parity bit
// (parameter ODD_PARITY selects odd parity) after the data bits.
module serial_out_shifter
    import serial_out_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   DIV        = 1,
    parameter logic IDLE_LEVEL = 1'b0
`ifdef SERIAL_OUT_PARITY_EN
    ,
    parameter logic ODD_PARITY = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_out_shifter_if.slave  ld,
    output logic                 serialOut,
    output logic                 busy,
    output logic                 done
);

    localparam int            BW       = clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] word_ord;
    logic [BW-1:0]     bit_cnt;
    logic              so_q;
    logic              busy_q;
    logic              rdy_en;
    logic              tick;
    logic              last_cycle;
    logic              accept;
`ifdef SERIAL_OUT_PARITY_EN
    logic              par_q;
`endif

    bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (state != ST_IDLE),
        .tick (tick)
    );

    // Reorder the incoming word so that bit 0 of the shift register is
    // always the next bit to send; the shifter then only shifts right.
    always_comb begin
        word_ord = ld.load_data;
        if (ld.msb_first) begin
            for (int i = 0; i < DATA_W; i++) begin
                word_ord[i] = ld.load_data[DATA_W-1-i];
            end
        end
    end

    // Final cycle of the word: last data bit, or the parity bit when present.
`ifdef SERIAL_OUT_PARITY_EN
    assign last_cycle = (state == ST_PARITY) && tick;
`else
    assign last_cycle = (state == ST_SHIFT) && (bit_cnt == LAST_BIT) && tick;
`endif

    // rdy_en keeps load_ready low until the first edge after reset release.
    assign ld.load_ready = rdy_en && ((state == ST_IDLE) || last_cycle);
    assign accept        = ld.load_valid && ld.load_ready;

    assign done      = last_cycle;
    assign serialOut = so_q;
    assign busy      = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            so_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            rdy_en  <= 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            rdy_en <= 1'b1;
            // Accept is only possible in IDLE or the final cycle, so it takes
            // priority and gives gap-free streaming into the next word.
            if (accept) begin
                state   <= ST_SHIFT;
                sr      <= word_ord;
                so_q    <= word_ord[0];
                bit_cnt <= '0;
                busy_q  <= 1'b1;
`ifdef SERIAL_OUT_PARITY_EN
                par_q   <= (^ld.load_data) ^ ODD_PARITY;
`endif
            end else if (last_cycle) begin
                state   <= ST_IDLE;
                so_q    <= IDLE_LEVEL;
                busy_q  <= 1'b0;
                bit_cnt <= '0;
            end else if ((state == ST_SHIFT) && tick) begin
`ifdef SERIAL_OUT_PARITY_EN
                if (bit_cnt == LAST_BIT) begin
                    state <= ST_PARITY;
                    so_q  <= par_q;
                end else
`endif
                begin
                    bit_cnt <= bit_cnt + BW'(1);
                    sr      <= sr >> 1;
                    so_q    <= sr[1];
                end
            end
        end
    end

endmodule
